// File: rtl/spi_pkg.sv
// Shared constants and the state encoding for the SPI frame controller.
package spi_pkg;

   localparam int FRAME_WIDTH = 8;
   localparam logic RW_READ = 1'b1;

   typedef enum logic [3:0] {
      IDLE         = 4'd0,
      GET_ADDR     = 4'd1,
      GOT_ADDR     = 4'd2,
      READ_WAIT    = 4'd3,
      READ_LOAD    = 4'd4,
      READ         = 4'd5,
      WRITE        = 4'd6,
      WRITE_COMMIT = 4'd7,
      DONE         = 4'd8
   } state_t;

endpackage

// File: rtl/spi_bit_counter.sv
// Saturating bit counter used to measure address and data phases of a frame.
module spi_bit_counter #(
   parameter int width    = 8,
   parameter int cntWidth = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic                enable,
   output logic [cntWidth-1:0] count,
   output logic                done
);

   localparam logic [cntWidth-1:0] FULL = cntWidth'(width);

   // Clear wins over enable; the count sticks at width instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != FULL)) begin
         count <= count + 1'b1;
      end
   end

   assign done = (count == FULL);

endmodule

// File: rtl/spi_frame_controller.sv
// Frame-level control FSM between the SPI shift register and the data memory.
module spi_frame_controller
   import spi_pkg::*;
#(
   parameter int width    = FRAME_WIDTH,
   parameter int cntWidth = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cs,
   input  logic             sclkPosEdge,
   input  logic             sclkNegEdge,
   input  logic [width-1:0] shiftRegIn,
   output logic             parallelLoad,
   output logic             misoBufe,
   output logic             dmWrEn,
   output logic [width-2:0] address,
   output logic             busy
);

   localparam logic [cntWidth-1:0] LAST = cntWidth'(width - 1);

   state_t                state;
   logic                  cnt_clear;
   logic                  cnt_enable;
   logic [cntWidth-1:0]   count;
   logic                  cnt_done;
   logic                  last_edge;

   // Only the strobe that matters in the current phase advances the count.
   always_comb begin
      cnt_clear  = cs || (state == IDLE) || (state == GOT_ADDR);
      cnt_enable = 1'b0;
      case (state)
         GET_ADDR, WRITE: cnt_enable = sclkPosEdge;
         READ:            cnt_enable = sclkNegEdge;
         default:         cnt_enable = 1'b0;
      endcase
      last_edge = (cnt_enable && (count == LAST)) || cnt_done;
   end

   spi_bit_counter #(
      .width    (width),
      .cntWidth (cntWidth)
   ) u_bit_counter (
      .clk    (clk),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (cnt_enable),
      .count  (count),
      .done   (cnt_done)
   );

   // Outputs are registered alongside the state so they are a pure decode of it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         address      <= '0;
         parallelLoad <= 1'b0;
         misoBufe     <= 1'b0;
         dmWrEn       <= 1'b0;
         busy         <= 1'b0;
      end else begin : step
         state_t nxt;
         nxt = state;
         if (cs && (state != IDLE)) begin
            nxt = IDLE;
         end else begin
            case (state)
               IDLE:         if (!cs) nxt = GET_ADDR;
               GET_ADDR:     if (last_edge) nxt = GOT_ADDR;
               GOT_ADDR: begin
                  address <= shiftRegIn[width-2:0];
                  nxt = (shiftRegIn[width-1] == RW_READ) ? READ_WAIT : WRITE;
               end
               READ_WAIT:    nxt = READ_LOAD;
               READ_LOAD:    nxt = READ;
               READ:         if (last_edge) nxt = DONE;
               WRITE:        if (last_edge) nxt = WRITE_COMMIT;
               WRITE_COMMIT: nxt = DONE;
               DONE:         nxt = DONE;
               default:      nxt = IDLE;
            endcase
         end
         state        <= nxt;
         parallelLoad <= (nxt == READ_LOAD);
         misoBufe     <= (nxt == READ);
         dmWrEn       <= (nxt == WRITE_COMMIT);
         busy         <= (nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_spi_frame_controller.sv
// Self-checking bench: directed frame table, randomized frames against a frame-level model, corner sequences.
module tb_spi_frame_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       cs;
   logic       sclkPosEdge;
   logic       sclkNegEdge;
   logic [7:0] sr;
   logic       parallelLoad;
   logic       misoBufe;
   logic       dmWrEn;
   logic [6:0] address;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   int         cyc = 0;
   int         dm_total = 0;
   int         pl_total = 0;
   int         dm_last_cyc = -1;
   int         pl_last_cyc = -1;
   int         miso_last_cyc = -1;
   logic [6:0] dm_addr = '0;
   logic [6:0] model_addr = '0;

   typedef struct {
      logic [7:0] frame;
      int         abort_k;
      int         exp_dm;
      int         exp_pl;
      logic [6:0] exp_addr;
   } vec_t;

   spi_frame_controller dut (
      .clk          (clk),
      .reset        (reset),
      .cs           (cs),
      .sclkPosEdge  (sclkPosEdge),
      .sclkNegEdge  (sclkNegEdge),
      .shiftRegIn   (sr),
      .parallelLoad (parallelLoad),
      .misoBufe     (misoBufe),
      .dmWrEn       (dmWrEn),
      .address      (address),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Event monitor: counts strobes and remembers when they happened.
   always @(negedge clk) begin
      if (dmWrEn) begin
         dm_total    <= dm_total + 1;
         dm_last_cyc <= cyc;
         dm_addr     <= address;
      end
      if (parallelLoad) begin
         pl_total    <= pl_total + 1;
         pl_last_cyc <= cyc;
      end
      if (misoBufe) miso_last_cyc <= cyc;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Frame-level reference: which effects a frame must have, given where (if anywhere) cs aborted it.
   function automatic void model_frame(input logic [7:0] frame, input int abort_k,
                                       input logic [6:0] prev, output int dm,
                                       output int pl, output logic [6:0] addr);
      int eff;
      eff  = (abort_k == 0) ? 16 : abort_k - 1;
      addr = (eff >= 8) ? frame[6:0] : prev;
      dm   = (!frame[7] && eff == 16) ? 1 : 0;
      pl   = (frame[7] && eff >= 8) ? 1 : 0;
   endfunction

   // One-clk strobe; a posedge also shifts the modelled shift register right, MSB in.
   task automatic apply_stimulus(input bit is_pos, input bit noise, input bit din,
                                 input bit raise_cs, output int at_cyc);
      sclkPosEdge = is_pos | noise;
      sclkNegEdge = !is_pos | noise;
      if (is_pos) sr = {din, sr[7:1]};
      if (raise_cs) cs = 1'b1;
      at_cyc = cyc;
      @(negedge clk);
      sclkPosEdge = 1'b0;
      sclkNegEdge = 1'b0;
   endtask

   task automatic run_frame(input logic [7:0] frame, input int abort_k, input bit rand_gaps,
                            input bit hold_cs, input int exp_dm, input int exp_pl,
                            input logic [6:0] exp_addr);
      int s8, s16, at, dm0, pl0;
      bit is_pos, din, aborted;
      dm0 = dm_total;
      pl0 = pl_total;
      s8 = -100;
      s16 = -100;
      aborted = 1'b0;
      cs = 1'b0;
      @(negedge clk);
      for (int k = 1; k <= 16; k++) begin
         is_pos = (k <= 8) || !frame[7];
         din = (k <= 8) ? frame[k-1] : 1'($urandom);
         apply_stimulus(is_pos, rand_gaps && ($urandom_range(0, 3) == 0), din, k == abort_k, at);
         if (k == 8) s8 = at;
         if (k == 16) s16 = at;
         if (k == abort_k) begin
            check_output("abort_busy", busy, 0);
            aborted = 1'b1;
            break;
         end
         if (k == 8) repeat (4) @(negedge clk);
         else if (rand_gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      if (!aborted) begin
         repeat (2) @(negedge clk);
         if (!hold_cs) cs = 1'b1;
      end
      repeat (2) @(negedge clk);
      check_output("dm_count", dm_total - dm0, exp_dm);
      check_output("pl_count", pl_total - pl0, exp_pl);
      check_output("address", address, exp_addr);
      if (!hold_cs) begin
         check_output("busy_after", busy, 0);
         check_output("miso_after", misoBufe, 0);
      end
      if (exp_dm == 1) begin
         check_output("dm_latency", dm_last_cyc - s16, 1);
         check_output("dm_addr", dm_addr, exp_addr);
      end
      if (exp_pl == 1) check_output("pl_latency", pl_last_cyc - s8, 3);
      if (frame[7] && !aborted) check_output("miso_drop", miso_last_cyc, s16);
   endtask

   initial begin
      vec_t       table_v[7];
      int         at, dm0, e_dm, e_pl, abort_k;
      logic [7:0] frame;
      logic [6:0] e_addr;

      table_v[0] = '{8'h25, 0,  1, 0, 7'h25};
      table_v[1] = '{8'hA5, 0,  0, 1, 7'h25};
      table_v[2] = '{8'h25, 13, 0, 0, 7'h25};
      table_v[3] = '{8'h33, 8,  0, 0, 7'h25};
      table_v[4] = '{8'h7F, 0,  1, 0, 7'h7F};
      table_v[5] = '{8'h80, 0,  0, 1, 7'h00};
      table_v[6] = '{8'hC1, 11, 0, 1, 7'h41};

      reset = 1'b1;
      cs = 1'b1;
      sclkPosEdge = 1'b0;
      sclkNegEdge = 1'b0;
      sr = 8'($urandom);
      repeat (3) @(negedge clk);
      check_output("rst_busy", busy, 0);
      check_output("rst_address", address, 0);
      check_output("rst_pl", parallelLoad, 0);
      check_output("rst_miso", misoBufe, 0);
      check_output("rst_dm", dmWrEn, 0);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] directed frame table");
      for (int i = 0; i < 7; i++) begin
         run_frame(table_v[i].frame, table_v[i].abort_k, 1'b0, 1'b0,
                   table_v[i].exp_dm, table_v[i].exp_pl, table_v[i].exp_addr);
         model_addr = table_v[i].exp_addr;
      end

      $display("[TB] randomized frames");
      for (int i = 0; i < 24; i++) begin
         frame = 8'($urandom);
         abort_k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0;
         model_frame(frame, abort_k, model_addr, e_dm, e_pl, e_addr);
         run_frame(frame, abort_k, 1'b1, 1'b0, e_dm, e_pl, e_addr);
         model_addr = e_addr;
      end

      $display("[TB] extra edges in DONE with cs held low");
      run_frame(8'h11, 0, 1'b0, 1'b1, 1, 0, 7'h11);
      dm0 = dm_total;
      for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, at);
      @(negedge clk);
      check_output("done_busy", busy, 1);
      check_output("done_no_dm", dm_total - dm0, 0);
      cs = 1'b1;
      repeat (2) @(negedge clk);
      check_output("done_exit_busy", busy, 0);
      run_frame(8'h12, 0, 1'b0, 1'b0, 1, 0, 7'h12);

      $display("[TB] asynchronous reset mid-address");
      cs = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, at);
      check_output("pre_reset_busy", busy, 1);
      #2 reset = 1'b1;
      #1;
      check_output("async_busy", busy, 0);
      check_output("async_address", address, 0);
      check_output("async_pl", parallelLoad, 0);
      check_output("async_miso", misoBufe, 0);
      check_output("async_dm", dmWrEn, 0);
      cs = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_output("post_reset_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
